// File: rtl/snn_img_loader.sv
// ============================================================================
// snn_img_loader
//
// Upstream stage of the SNN core. Accepts a byte-wide pixel stream through a
// valid/ready handshake and packs four pixels into each 32-bit BRAM word,
// written through the image BRAM's second port. Once a full frame is stored,
// it issues a single-cycle learn or inference start pulse, waits for the
// controller's done level and captures the winner index.
//
// Optional build macro: SNN_LOADER_TIMEOUT_EN
//   When defined, WAIT is bounded by a 20-bit watchdog of TIMEOUT_CYC cycles.
//   On expiry the result is reported as winner 8'hFF and the sticky o_timeout
//   output is set. When undefined, WAIT is unbounded, and neither o_timeout
//   nor the TIMEOUT_CYC parameter exists.
//
// Parameters:
//   N_WORDS      words per frame (1..256), 4 pixels per word
//   TIMEOUT_CYC  watchdog limit in WAIT (only with SNN_LOADER_TIMEOUT_EN)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_valid/s_ready       pixel beat handshake
//   s_data, s_last        pixel value, final pixel of the frame
//   i_mode                0 = inference, 1 = learn (sampled on first beat)
//   i_idle, i_done        SNN controller idle / done (done is a level)
//   i_winner              SNN winner index
//   o_lern, o_infr        single-cycle start pulses
//   o_d, o_addr, o_ce, o_we  registered BRAM write port
//   o_res_valid           single-cycle result pulse
//   o_res_winner          captured winner, held until the next result
//   o_short, o_overflow   sticky frame-length flags, cleared at frame start
//   o_busy                high in any state other than IDLE
//   o_timeout             sticky watchdog flag (optional build only)
// ============================================================================
module snn_img_loader #(
    parameter int N_WORDS = 196
`ifdef SNN_LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1000000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    input  logic        i_mode,
    input  logic        i_idle,
    input  logic        i_done,
    input  logic [7:0]  i_winner,
    output logic        o_lern,
    output logic        o_infr,
    output logic [31:0] o_d,
    output logic [7:0]  o_addr,
    output logic        o_ce,
    output logic        o_we,
    output logic        o_res_valid,
    output logic [7:0]  o_res_winner,
    output logic        o_short,
    output logic        o_overflow,
    output logic        o_busy
`ifdef SNN_LOADER_TIMEOUT_EN
    ,
    output logic        o_timeout
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_DRAIN,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [7:0] LAST_WORD = 8'(N_WORDS - 1);

`ifdef SNN_LOADER_TIMEOUT_EN
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYC - 1);
    logic [19:0] to_cnt_reg;
`endif

    state_t      state_reg;
    logic [7:0]  word_idx_reg;   // word being packed, or next FILL address
    logic [1:0]  lane_reg;       // byte lane of the next pixel
    logic [31:0] pack_reg;       // partially packed word; unused lanes stay 0
    logic        mode_reg;
    logic        run_reg;        // low while in reset so s_ready reads 0

    logic        pix_fire;
    logic        word_done;
    logic [31:0] word_cur;

    assign s_ready  = run_reg && ((state_reg == ST_IDLE) ||
                                  (state_reg == ST_LOAD) ||
                                  (state_reg == ST_DRAIN));
    assign pix_fire = s_valid && s_ready &&
                      ((state_reg == ST_IDLE) || (state_reg == ST_LOAD));
    assign word_done = (lane_reg == 2'd3) || s_last;
    assign o_busy   = (state_reg != ST_IDLE);

    // Word as it looks with the current beat merged in. Lanes above the
    // current one are still zero in pack_reg, which gives the zero padding
    // of a word cut short by s_last for free.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word_cur[8*gi +: 8] = (lane_reg == 2'(gi)) ? s_data
                                                              : pack_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            word_idx_reg <= '0;
            lane_reg     <= '0;
            pack_reg     <= '0;
            mode_reg     <= 1'b0;
            run_reg      <= 1'b0;
            o_lern       <= 1'b0;
            o_infr       <= 1'b0;
            o_d          <= '0;
            o_addr       <= '0;
            o_ce         <= 1'b0;
            o_we         <= 1'b0;
            o_res_valid  <= 1'b0;
            o_res_winner <= '0;
            o_short      <= 1'b0;
            o_overflow   <= 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
            to_cnt_reg   <= '0;
            o_timeout    <= 1'b0;
`endif
        end else begin
            run_reg     <= 1'b1;
            o_ce        <= 1'b0;
            o_we        <= 1'b0;
            o_lern      <= 1'b0;
            o_infr      <= 1'b0;
            o_res_valid <= 1'b0;

            case (state_reg)
                ST_IDLE, ST_LOAD: begin
                    if (pix_fire) begin
                        if (state_reg == ST_IDLE) begin
                            // Frame start: latch mode, clear sticky flags.
                            mode_reg   <= i_mode;
                            o_short    <= 1'b0;
                            o_overflow <= 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
                            o_timeout  <= 1'b0;
`endif
                        end
                        state_reg <= ST_LOAD;
                        if (word_done) begin
                            o_ce     <= 1'b1;
                            o_we     <= 1'b1;
                            o_addr   <= word_idx_reg;
                            o_d      <= word_cur;
                            pack_reg <= '0;
                            lane_reg <= '0;
                            if (word_idx_reg == LAST_WORD) begin
                                word_idx_reg <= '0;
                                if ((lane_reg == 2'd3) && !s_last) begin
                                    // Frame full but no s_last yet: swallow the rest.
                                    o_overflow <= 1'b1;
                                    state_reg  <= ST_DRAIN;
                                end else begin
                                    if (lane_reg != 2'd3) begin
                                        o_short <= 1'b1;
                                    end
                                    state_reg <= ST_START;
                                end
                            end else begin
                                word_idx_reg <= word_idx_reg + 8'd1;
                                if (s_last) begin
                                    o_short   <= 1'b1;
                                    state_reg <= ST_FILL;
                                end
                            end
                        end else begin
                            pack_reg <= word_cur;
                            lane_reg <= lane_reg + 2'd1;
                        end
                    end
                end

                ST_FILL: begin
                    o_ce   <= 1'b1;
                    o_we   <= 1'b1;
                    o_addr <= word_idx_reg;
                    o_d    <= '0;
                    if (word_idx_reg == LAST_WORD) begin
                        word_idx_reg <= '0;
                        state_reg    <= ST_START;
                    end else begin
                        word_idx_reg <= word_idx_reg + 8'd1;
                    end
                end

                ST_DRAIN: begin
                    if (s_valid && s_ready && s_last) begin
                        state_reg <= ST_START;
                    end
                end

                ST_START: begin
                    if (i_idle) begin
                        if (mode_reg) begin
                            o_lern <= 1'b1;
                        end else begin
                            o_infr <= 1'b1;
                        end
`ifdef SNN_LOADER_TIMEOUT_EN
                        to_cnt_reg <= '0;
`endif
                        state_reg <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (i_done) begin
                        o_res_winner <= i_winner;
                        o_res_valid  <= 1'b1;
                        state_reg    <= ST_DONE;
                    end
`ifdef SNN_LOADER_TIMEOUT_EN
                    else if (to_cnt_reg == TO_LAST) begin
                        o_res_winner <= 8'hFF;
                        o_res_valid  <= 1'b1;
                        o_timeout    <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 20'd1;
                    end
`endif
                end

                ST_DONE: begin
                    // Wait for done to drop so a held level cannot retrigger.
                    if (!i_done) begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
